// File: rtl/instr_mem_loader.sv
// Instruction memory loader: receives a length-prefixed byte stream, packs the bytes into
// DATA_W-bit words, writes them to instruction memory, and holds the CPU until the load is done.
module instr_mem_loader #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 9,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              start,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold
);

  localparam int HI_W = DATA_W - 8;

  typedef enum logic [2:0] {
    S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_DONE, S_ERROR
  } state_t;

  state_t            r_state;
  logic [7:0]        r_len_lo;
  logic [7:0]        r_lo;
  logic [10:0]       r_len;
  logic [10:0]       r_cnt;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic              r_cpu_hold;

  logic              w_ready;
  logic              w_accept;
  logic [10:0]       w_len;
  logic              w_len_bad;
  logic              w_hi_bad;

  // Ready while any of the four receiving states is active.
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI: w_ready = 1'b1;
      default:                                  w_ready = 1'b0;
    endcase
  end

  assign w_accept  = in_valid && w_ready;
  assign w_len     = {in_data[2:0], r_len_lo};
  assign w_len_bad = (w_len == 11'd0) || (32'(w_len) > 32'(MAX_WORDS)) || (in_data[7:3] != 5'd0);
  // Any high-byte bit that does not fit in the instruction word is a protocol error.
  assign w_hi_bad  = ((in_data >> HI_W) != 8'd0);

  // Loader FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_LEN_LO;
      r_len_lo   <= 8'd0;
      r_lo       <= 8'd0;
      r_len      <= 11'd0;
      r_cnt      <= 11'd0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_cpu_hold <= 1'b1;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_LEN_LO: begin
          if (w_accept) begin
            r_len_lo <= in_data;
            r_state  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (w_accept) begin
            if (w_len_bad) begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_len   <= w_len;
              r_cnt   <= 11'd0;
              r_state <= S_DATA_LO;
            end
          end
        end
        S_DATA_LO: begin
          if (w_accept) begin
            r_lo    <= in_data;
            r_state <= S_DATA_HI;
          end
        end
        S_DATA_HI: begin
          if (w_accept) begin
            if (w_hi_bad) begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= ADDR_W'(r_cnt);
              r_wr_data <= {in_data[HI_W-1:0], r_lo};
              r_cnt     <= r_cnt + 11'd1;
              if (r_cnt == r_len - 11'd1) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
              end else begin
                r_state <= S_DATA_LO;
              end
            end
          end
        end
        S_DONE: begin
          // Release the CPU only once the final write pulse has gone out.
          if (start) begin
            r_state    <= S_LEN_LO;
            r_done     <= 1'b0;
            r_busy     <= 1'b1;
            r_cpu_hold <= 1'b1;
            r_cnt      <= 11'd0;
            r_len      <= 11'd0;
          end else begin
            r_cpu_hold <= 1'b0;
          end
        end
        S_ERROR: begin
          if (start) begin
            r_state    <= S_LEN_LO;
            r_error    <= 1'b0;
            r_busy     <= 1'b1;
            r_cpu_hold <= 1'b1;
            r_cnt      <= 11'd0;
            r_len      <= 11'd0;
          end else begin
            r_cpu_hold <= 1'b1;
          end
        end
        default: begin
          r_state <= S_ERROR;
          r_error <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = w_ready;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;
  assign cpu_hold = r_cpu_hold;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: stimulus pushes expected writes, a monitor pops and
// compares them on every wr_en pulse.
module tb_instr_mem_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       start = 1'b0;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [8:0] wr_data;
  logic       busy, done, error, cpu_hold;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [9:0] addr;
    logic [8:0] data;
    logic       last;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  logic [7:0] tog_bytes [8] = '{8'h03, 8'h00, 8'hA5, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h01};
  logic [8:0] tog_words [3] = '{9'h1A5, 9'h0FF, 9'h100};

  instr_mem_loader #(.ADDR_W(10), .DATA_W(9), .MAX_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .start(start), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .done(done), .error(error), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every wr_en cycle must match the next expected write.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_wr: got addr=%0h data=%0h expected no write", wr_addr, wr_data);
      end else begin
        mon_e = q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
        chk("wr_data", 32'(wr_data), 32'(mon_e.data));
        chk("done_with_wr", 32'(done), 32'(mon_e.last));
      end
    end
  end

  // Present a byte and return #1 after the edge on which it was accepted.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=%0b expected 1 within 20 cycles", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [9:0] a, input logic [8:0] d, input logic last);
    q.push_back('{addr: a, data: d, last: last});
    send_byte(d[7:0]);
    send_byte({7'd0, d[8]});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    idle(1);

    // Back-to-back 3-word frame.
    send_byte(8'h03);
    send_byte(8'h00);
    send_word(10'd0, 9'h1A5, 1'b0);
    send_word(10'd1, 9'h0FF, 1'b0);
    send_word(10'd2, 9'h100, 1'b1);
    chk("b2b_done", 32'(done), 32'd1);
    chk("b2b_hold_still", 32'(cpu_hold), 32'd1);
    chk("b2b_wr_en_last", 32'(wr_en), 32'd1);
    idle(1);
    chk("b2b_hold_fall", 32'(cpu_hold), 32'd0);
    chk("b2b_in_ready", 32'(in_ready), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd0);
    idle(2);
    chk("b2b_no_extra_wr", 32'(q.size()), 32'd0);
    pulse_start();
    chk("rearm_done", 32'(done), 32'd0);
    chk("rearm_hold", 32'(cpu_hold), 32'd1);
    chk("rearm_busy", 32'(busy), 32'd1);

    // Same frame, in_valid toggling.
    for (int i = 0; i < 8; i++) begin
      if (i >= 2 && (i % 2) == 0)
        q.push_back('{addr: 10'((i - 2) / 2), data: tog_words[(i - 2) / 2], last: (i == 6)});
      send_byte(tog_bytes[i]);
      if (i >= 3 && (i % 2) == 1) chk("tog_wr_lat1", 32'(wr_en), 32'd1);
      in_valid = 1'b0;
      if (i < 7) chk("tog_busy", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      if (i < 7) chk("tog_busy_gap", 32'(busy), 32'd1);
    end
    chk("tog_done", 32'(done), 32'd1);
    chk("tog_error", 32'(error), 32'd0);
    pulse_start();

    // Zero length -> error, then recover with a 1-word frame.
    send_byte(8'h00);
    send_byte(8'h00);
    chk("len0_error", 32'(error), 32'd1);
    chk("len0_busy", 32'(busy), 32'd0);
    chk("len0_in_ready", 32'(in_ready), 32'd0);
    idle(3);
    chk("len0_hold", 32'(cpu_hold), 32'd1);
    pulse_start();
    chk("len0_err_clr", 32'(error), 32'd0);
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(10'd0, 9'h02C, 1'b1);
    chk("rec_done", 32'(done), 32'd1);
    chk("rec_error", 32'(error), 32'd0);
    idle(2);
    pulse_start();

    // Oversized high data byte -> error, no write.
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h55);
    send_byte(8'h02);
    chk("hibad_error", 32'(error), 32'd1);
    idle(3);
    chk("hibad_hold", 32'(cpu_hold), 32'd1);
    pulse_start();

    // L = 1025 -> error.
    send_byte(8'h01);
    send_byte(8'h04);
    chk("len1025_error", 32'(error), 32'd1);
    idle(2);
    pulse_start();

    // Maximum length 1024 with incrementing data.
    send_byte(8'h00);
    send_byte(8'h04);
    chk("len1024_ok", 32'(error), 32'd0);
    for (int i = 0; i < 1024; i++) begin
      q.push_back('{addr: 10'(i), data: 9'(i), last: (i == 1023)});
      send_byte(8'(i));
      if (i == 1023) chk("max_done_early", 32'(done), 32'd0);
      send_byte({7'd0, 1'(i >> 8)});
    end
    chk("max_done", 32'(done), 32'd1);
    idle(2);
    chk("max_sb_empty", 32'(q.size()), 32'd0);
    pulse_start();

    // Reset after the low byte of word 2.
    send_byte(8'h03);
    send_byte(8'h00);
    send_word(10'd0, 9'h1A5, 1'b0);
    send_word(10'd1, 9'h0FF, 1'b0);
    send_byte(8'h00);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd1);
    chk("midrst_hold", 32'(cpu_hold), 32'd1);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_wr_en", 32'(wr_en), 32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(10'd0, 9'h134, 1'b0);
    send_word(10'd1, 9'h078, 1'b1);
    chk("fresh_done", 32'(done), 32'd1);
    idle(3);
    chk("fresh_hold", 32'(cpu_hold), 32'd0);
    chk("final_sb_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
